alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 172 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared multi-cycle ALU, one transaction in flight.
// Optional WAIT watchdog enabled by defining ALU_ARB_TIMEOUT_EN (limit set by TIMEOUT).
module alu_arbiter #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    input  logic [3:0]          req_op,
    input  logic [2*DATA_W-1:0] req_a,
    input  logic [2*DATA_W-1:0] req_b,
    output logic [1:0]          req_ready,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [2*DATA_W-1:0] rsp_data,
    output logic                rsp_err,
    output logic                alu_start,
    output logic [1:0]          alu_op,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    input  logic                alu_done,
    input  logic [2*DATA_W-1:0] alu_result,
    output logic                alu_abort,
    output logic                busy
);
    // state  | meaning
    // IDLE   | waiting for a request, grant and capture operands
    // ISSUE  | one-cycle alu_start pulse
    // WAIT   | waiting for alu_done (or watchdog expiry)
    // RESP   | rsp_valid to granted requester until its rsp_ready
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]          state_q, state_d;
    logic                gnt_q, gnt_d;
    logic                rr_q, rr_d;
    logic [1:0]          op_q, op_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [2*DATA_W-1:0] data_q, data_d;
    logic                err_q, err_d;

    logic                sel;
    logic                accept;
    logic                to_hit;
    logic                alu_drive;
    logic [1:0]          sel_op;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;

    // rr_q names the requester that wins when both are asking
    always_comb begin
        sel = rr_q;
        if (req_valid == 2'b01) begin
            sel = 1'b0;
        end else if (req_valid == 2'b10) begin
            sel = 1'b1;
        end
    end

    assign accept = (state_q == S_IDLE) && (req_valid != 2'b00);
    assign sel_op = sel ? req_op[3:2] : req_op[1:0];
    assign sel_a  = sel ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
    assign sel_b  = sel ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] cnt_q;

    // Loaded in ISSUE so terminal count lands on the TIMEOUT-th WAIT cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == S_ISSUE) begin
            cnt_q <= CNT_W'(TIMEOUT - 1);
        end else if ((state_q == S_WAIT) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign to_hit = (state_q == S_WAIT) && !alu_done && (cnt_q == '0);
`else
    // No watchdog: folds to constant 0
    assign to_hit = (TIMEOUT < 0);
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    gnt_d = sel;
                    op_d  = sel_op;
                    a_d   = sel_a;
                    b_d   = sel_b;
                    if ((sel_op == 2'b11) && (sel_b == '0)) begin
                        data_d  = '1;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (alu_done) begin
                    data_d  = alu_result;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (to_hit) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready[gnt_q]) begin
                    rr_d    = ~gnt_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gnt_q   <= 1'b0;
            rr_q    <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // req_ready is combinational from req_valid, so reset must mask it explicitly
    assign req_ready = (rst_n && accept) ? (sel ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_valid = (state_q == S_RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;
    assign alu_drive = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign alu_start = (state_q == S_ISSUE);
    assign alu_op    = alu_drive ? op_q : '0;
    assign alu_a     = alu_drive ? a_q : '0;
    assign alu_b     = alu_drive ? b_q : '0;
    assign alu_abort = to_hit;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: scoreboard of expected responses, immediate-assertion checks.
// Watchdog scenario is compiled in when ALU_ARB_TIMEOUT_EN is defined.
module tb_alu_arbiter;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 64;

    typedef struct {
        int          r;
        logic [15:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [3:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        alu_start;
    logic [1:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        alu_abort;
    logic        busy;

    int   n_checks = 0;
    int   n_err    = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result), .alu_abort(alu_abort),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] alu_model(input logic [1:0] op, input logic [7:0] a,
                                              input logic [7:0] b);
        logic [15:0] wa, wb;
        wa = {8'd0, a};
        wb = {8'd0, b};
        case (op)
            2'b00:   return wa + wb;
            2'b01:   return wa - wb;
            2'b10:   return wa * wb;
            default: return (b == 8'd0) ? 16'hFFFF : wa / wb;
        endcase
    endfunction

    task automatic set_req(input int r, input logic [1:0] op, input logic [7:0] a,
                           input logic [7:0] b);
        req_op[2*r +: 2]         = op;
        req_a[DATA_W*r +: DATA_W] = a;
        req_b[DATA_W*r +: DATA_W] = b;
        req_valid[r]             = 1'b1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_alu_start"}, alu_start, 0);
        chk({tag, "_alu_op"}, alu_op, 0);
        chk({tag, "_alu_a"}, alu_a, 0);
        chk({tag, "_alu_b"}, alu_b, 0);
        chk({tag, "_alu_abort"}, alu_abort, 0);
    endtask

    // Entered at posedge+1 of an IDLE cycle with requests already driven; returns at
    // posedge+1 of the IDLE cycle following the response handshake.
    task automatic xact(input int g, input int lat, input int hold);
        logic [1:0] oh;
        logic [1:0] opv;
        logic [7:0] av, bv;
        logic       byp;
        exp_t       e;
        oh = (g == 1) ? 2'b10 : 2'b01;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("grant", req_ready, oh);
        opv = req_op[2*g +: 2];
        av  = req_a[DATA_W*g +: DATA_W];
        bv  = req_b[DATA_W*g +: DATA_W];
        byp = (opv == 2'b11) && (bv == 8'd0);
        sb.push_back('{g, alu_model(opv, av, bv), byp});
        @(posedge clk); #1;
        req_valid[g] = 1'b0;
        @(negedge clk);
        if (byp) begin
            chk("byp_no_start", alu_start, 0);
        end else begin
            chk("issue_start", alu_start, 1);
            chk("issue_op", alu_op, opv);
            chk("issue_a", alu_a, av);
            chk("issue_b", alu_b, bv);
            chk("issue_rsp", rsp_valid, 0);
            for (int i = 1; i < lat; i++) begin
                @(posedge clk); #1;
                @(negedge clk);
                chk("wait_no_start", alu_start, 0);
                chk("wait_a", alu_a, av);
                chk("wait_rsp", rsp_valid, 0);
                chk("wait_ready", req_ready, 0);
            end
            @(posedge clk); #1;
            alu_done   = 1'b1;
            alu_result = alu_model(opv, av, bv);
            @(posedge clk); #1;
            alu_done   = 1'b0;
            alu_result = '0;
            @(negedge clk);
        end
        e = sb.pop_front();
        chk("rsp_valid", rsp_valid, (e.r == 1) ? 2'b10 : 2'b01);
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_err", rsp_err, e.err);
        chk("resp_alu_a", alu_a, 0);
        chk("resp_alu_op", alu_op, 0);
        chk("resp_req_ready", req_ready, 0);
        rsp_ready = ~oh;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("hold_valid", rsp_valid, oh);
            chk("hold_data", rsp_data, e.data);
            chk("hold_req_ready", req_ready, 0);
        end
        rsp_ready = oh;
        @(posedge clk); #1;
        rsp_ready = 2'b00;
    endtask

    initial begin
        int  n;
        logic seen;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        rsp_ready  = '0;
        alu_done   = 1'b0;
        alu_result = '0;
        #2;
        chk_zero("por");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Contention from reset: 0, then 1, then 0
        set_req(0, 2'b00, 8'd5, 8'd3);
        set_req(1, 2'b01, 8'd20, 8'd7);
        xact(0, 2, 0);
        set_req(0, 2'b10, 8'd6, 8'd7);
        xact(1, 3, 0);
        set_req(1, 2'b11, 8'd100, 8'd9);
        xact(0, 1, 0);

        // Reset during WAIT of a req1 transaction
        set_req(0, 2'b00, 8'd1, 8'd1);
        @(negedge clk);
        chk("rr_grant_req1", req_ready, 2'b10);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_alu_a", alu_a, 100);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_rsp", rsp_valid, 0);
            chk("rst_hold_busy", busy, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        xact(0, 2, 0);
        xact(1, 1, 0);

        // Single add, done four cycles after alu_start
        set_req(0, 2'b00, 8'd5, 8'd3);
        xact(0, 4, 0);
        // Minimum latency, wrapping subtract
        set_req(1, 2'b01, 8'd3, 8'd10);
        xact(1, 1, 0);
        // Divide by zero bypasses the ALU
        set_req(1, 2'b11, 8'd9, 8'd0);
        xact(1, 0, 0);
        // Response back-pressure with the other requester waiting
        set_req(0, 2'b10, 8'd12, 8'd11);
        set_req(1, 2'b00, 8'd255, 8'd255);
        xact(0, 2, 10);
        xact(1, 2, 0);

`ifdef ALU_ARB_TIMEOUT_EN
        set_req(0, 2'b10, 8'd3, 8'd4);
        @(negedge clk);
        chk("to_grant", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("to_start", alu_start, 1);
        n    = 0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
            if (alu_abort) seen = 1'b1;
        end
        chk("to_abort_seen", seen, 1);
        chk("to_wait_cycles", n, TIMEOUT);
        @(posedge clk); #1;
        @(negedge clk);
        chk("to_abort_pulse", alu_abort, 0);
        chk("to_rsp_valid", rsp_valid, 2'b01);
        chk("to_rsp_err", rsp_err, 1);
        chk("to_rsp_data", rsp_data, 0);
        rsp_ready = 2'b01;
        @(posedge clk); #1;
        rsp_ready = 2'b00;
`endif

        @(negedge clk);
        chk("final_idle", busy, 0);
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
